// File: rtl/multidiff_pkg.sv
// Shared definitions for the multi-channel handshake FSM.
// Holds the per-channel state encodings, the illegal-code boundary, the
// default parameter values and a small helper for illegal-code detection.
package multidiff_pkg;

  localparam int unsigned NCH_DEF = 3;
  localparam int unsigned DW_DEF  = 4;
  localparam int unsigned TMO_DEF = 8;
  localparam int unsigned SW      = 3;

  localparam logic [SW-1:0] ST_IDLE   = 3'd0;
  localparam logic [SW-1:0] ST_ARM    = 3'd1;
  localparam logic [SW-1:0] ST_RUN    = 3'd2;
  localparam logic [SW-1:0] ST_WAIT   = 3'd3;
  localparam logic [SW-1:0] ST_FIN    = 3'd4;
  // Codes from here up to 7 are unreachable in normal operation.
  localparam logic [SW-1:0] ST_ILL_LO = 3'd5;

  function automatic logic is_illegal(input logic [SW-1:0] s);
    return (s >= ST_ILL_LO);
  endfunction

endpackage

// File: rtl/multidiff_if.sv
// Bus bundle between a controller (master) and multidiff_fsm (slave).
// Inputs to the FSM : en, abort, start[NCH], done_in[NCH], cfg_len[DW]
// Outputs of the FSM: y_busy, y_req, y_fin, y_err [NCH], y_sync, state_dbg[3*NCH]
interface multidiff_if #(
  parameter int unsigned NCH = 3,
  parameter int unsigned DW  = 4
) ();
  logic             en;
  logic             abort;
  logic [NCH-1:0]   start;
  logic [NCH-1:0]   done_in;
  logic [DW-1:0]    cfg_len;
  logic [NCH-1:0]   y_busy;
  logic [NCH-1:0]   y_req;
  logic [NCH-1:0]   y_fin;
  logic             y_sync;
  logic [NCH-1:0]   y_err;
  logic [3*NCH-1:0] state_dbg;

  modport master (
    output en, abort, start, done_in, cfg_len,
    input  y_busy, y_req, y_fin, y_sync, y_err, state_dbg
  );

  modport slave (
    input  en, abort, start, done_in, cfg_len,
    output y_busy, y_req, y_fin, y_sync, y_err, state_dbg
  );
endinterface

// File: rtl/multidiff_fsm_diff_chan.sv
// One independent channel: IDLE -> ARM -> RUN (len cycles) -> WAIT -> FIN -> IDLE,
// with a WAIT timeout that raises a sticky error and returns to IDLE.
// Ports: clk, rst (sync, active-high), i_en, i_abort, i_start, i_done,
//        i_cfg_len[DW]; o_state[3] current code, o_err sticky error.
module diff_chan
  import multidiff_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_abort,
  input  logic          i_start,
  input  logic          i_done,
  input  logic [DW-1:0] i_cfg_len,
  output logic [SW-1:0] o_state,
  output logic          o_err
);

  localparam int unsigned TW = $clog2(TMO) + 1;

  logic [SW-1:0] r_state, w_state_nxt;
  logic [DW-1:0] r_len,   w_len_nxt;
  logic [DW-1:0] r_cnt,   w_cnt_nxt;
  logic [TW-1:0] r_tmo,   w_tmo_nxt;
  logic          r_err;
  logic          w_err_set;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmo   <= w_tmo_nxt;
      r_err   <= r_err | w_err_set;
    end
  end

  // Next-state logic: abort beats illegal recovery, which ignores en
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    w_err_set   = 1'b0;

    if (i_abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_tmo_nxt   = '0;
    end else if (is_illegal(r_state)) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_tmo_nxt   = '0;
      w_err_set   = 1'b1;
    end else if (i_en) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt = ST_ARM;
            // A zero length would never leave RUN, so treat it as one
            w_len_nxt   = (i_cfg_len == '0) ? DW'(1) : i_cfg_len;
          end
        end
        ST_ARM: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = r_len;
        end
        ST_RUN: begin
          if (r_cnt <= DW'(1)) begin
            w_state_nxt = ST_WAIT;
            w_tmo_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - DW'(1);
          end
        end
        ST_WAIT: begin
          if (i_done) begin
            w_state_nxt = ST_FIN;
          end else if (r_tmo >= TW'(TMO - 1)) begin
            w_state_nxt = ST_IDLE;
            w_err_set   = 1'b1;
          end else if (r_tmo != '1) begin
            w_tmo_nxt   = r_tmo + TW'(1);
          end
        end
        ST_FIN: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_err   = r_err;

endmodule

// File: rtl/multidiff_fsm.sv
// Top level: NCH independent handshake channels plus cross-channel sync flag.
// Ports: clk, rst (sync, active-high), bus (multidiff_if.slave) carrying
//        en/abort/start/done_in/cfg_len in and y_busy/y_req/y_fin/y_sync/
//        y_err/state_dbg out. Status outputs are Moore decodes of state.
module multidiff_fsm
  import multidiff_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  multidiff_if.slave  bus
);

  logic [SW-1:0]    w_state [NCH];
  logic [NCH-1:0]   w_err;
  logic [NCH-1:0]   w_busy;
  logic [NCH-1:0]   w_req;
  logic [NCH-1:0]   w_fin;
  logic [NCH-1:0]   w_err_q;
  logic [3*NCH-1:0] w_dbg;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    diff_chan #(
      .DW  (DW),
      .TMO (TMO)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_en      (bus.en),
      .i_abort   (bus.abort),
      .i_start   (bus.start[g]),
      .i_done    (bus.done_in[g]),
      .i_cfg_len (bus.cfg_len),
      .o_state   (w_state[g]),
      .o_err     (w_err[g])
    );

    // Decodes are masked during reset so nothing stale leaks out
    assign w_busy[g]          = ~rst & (w_state[g] != ST_IDLE);
    assign w_req[g]           = ~rst & (w_state[g] == ST_WAIT);
    assign w_fin[g]           = ~rst & (w_state[g] == ST_FIN);
    assign w_err_q[g]         = ~rst & w_err[g];
    assign w_dbg[SW*g +: SW]  = rst ? ST_IDLE : w_state[g];
  end

  assign bus.y_busy    = w_busy;
  assign bus.y_req     = w_req;
  assign bus.y_fin     = w_fin;
  assign bus.y_sync    = &w_fin;
  assign bus.y_err     = w_err_q;
  assign bus.state_dbg = w_dbg;

endmodule

// File: tb/tb_multidiff_fsm.sv
// Scoreboard bench for multidiff_fsm: stimulus pushes model predictions into a
// queue, an independent monitor pops and compares after each rising edge.
module tb_multidiff_fsm;

  localparam int unsigned NCH = 3;
  localparam int unsigned DW  = 4;
  localparam int unsigned TMO = 8;

  // Behavioural phases of a channel (values chosen to equal the debug codes)
  localparam int P_IDLE = 0;
  localparam int P_ARM  = 1;
  localparam int P_RUN  = 2;
  localparam int P_WAIT = 3;
  localparam int P_FIN  = 4;

  typedef struct {
    logic [3*NCH-1:0] dbg;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   fin;
    logic [NCH-1:0]   err;
    logic             sync;
  } exp_t;

  logic clk;
  logic rst;

  multidiff_if #(.NCH(NCH), .DW(DW)) bus ();

  multidiff_fsm #(.NCH(NCH), .DW(DW), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int   m_ph     [NCH];
  int   m_len    [NCH];
  int   m_left   [NCH];
  int   m_waited [NCH];
  logic m_err    [NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic a,
                            input logic [NCH-1:0] s, input logic [NCH-1:0] d,
                            input logic [DW-1:0] c);
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        m_ph[i] = P_IDLE; m_len[i] = 0; m_left[i] = 0; m_waited[i] = 0; m_err[i] = 1'b0;
      end else if (a) begin
        m_ph[i] = P_IDLE; m_left[i] = 0; m_waited[i] = 0;
      end else if (e) begin
        case (m_ph[i])
          P_IDLE: if (s[i]) begin
            m_ph[i]  = P_ARM;
            m_len[i] = (c == 0) ? 1 : int'(c);
          end
          P_ARM: begin
            m_ph[i]   = P_RUN;
            m_left[i] = m_len[i];
          end
          P_RUN: begin
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
              m_ph[i]     = P_WAIT;
              m_waited[i] = 0;
            end
          end
          P_WAIT: begin
            if (d[i]) m_ph[i] = P_FIN;
            else begin
              m_waited[i] = m_waited[i] + 1;
              if (m_waited[i] == TMO) begin
                m_ph[i]  = P_IDLE;
                m_err[i] = 1'b1;
              end
            end
          end
          default: m_ph[i] = P_IDLE;
        endcase
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t o;
    for (int i = 0; i < NCH; i++) begin
      o.dbg[3*i +: 3] = 3'(m_ph[i]);
      o.busy[i]       = (m_ph[i] != P_IDLE);
      o.req[i]        = (m_ph[i] == P_WAIT);
      o.fin[i]        = (m_ph[i] == P_FIN);
      o.err[i]        = m_err[i];
    end
    o.sync = &o.fin;
    return o;
  endfunction

  // One clock of stimulus: drive at the falling edge, predict the post-edge view
  task automatic cyc(input logic r, input logic e, input logic a,
                     input logic [NCH-1:0] s, input logic [NCH-1:0] d,
                     input logic [DW-1:0] c);
    @(negedge clk);
    rst         = r;
    bus.en      = e;
    bus.abort   = a;
    bus.start   = s;
    bus.done_in = d;
    bus.cfg_len = c;
    model_step(r, e, a, s, d, c);
    q.push_back(model_out());
  endtask

  task automatic idle(input int n, input logic e, input logic [NCH-1:0] d);
    repeat (n) cyc(1'b0, e, 1'b0, '0, d, '0);
  endtask

  // Monitor: compare every prediction shortly after the edge it refers to
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        ex = q.pop_front();
        chk("state_dbg", 32'(bus.state_dbg), 32'(ex.dbg));
        chk("y_busy",    32'(bus.y_busy),    32'(ex.busy));
        chk("y_req",     32'(bus.y_req),     32'(ex.req));
        chk("y_fin",     32'(bus.y_fin),     32'(ex.fin));
        chk("y_sync",    32'(bus.y_sync),    32'(ex.sync));
        chk("y_err",     32'(bus.y_err),     32'(ex.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.abort = 1'b0;
    bus.start = '0; bus.done_in = '0; bus.cfg_len = '0;
    for (int i = 0; i < NCH; i++) begin
      m_ph[i] = P_IDLE; m_len[i] = 0; m_left[i] = 0; m_waited[i] = 0; m_err[i] = 1'b0;
    end

    // Reset
    cyc(1'b1, 1'b1, 1'b0, '0, '0, '0);
    cyc(1'b1, 1'b1, 1'b0, 3'b111, '0, 4'd3);
    idle(2, 1'b1, '0);

    // Normal run on channel 0, length 3
    cyc(1'b0, 1'b1, 1'b0, 3'b001, '0, 4'd3);
    idle(6, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b0, '0, 3'b001, '0);
    idle(3, 1'b1, '0);

    // Timeout on channel 1, then a clean run with the error still set
    cyc(1'b0, 1'b1, 1'b0, 3'b010, '0, 4'd2);
    idle(3, 1'b1, '0);
    idle(8, 1'b1, '0);
    idle(2, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b0, 3'b010, '0, 4'd1);
    idle(3, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b0, '0, 3'b010, '0);
    idle(3, 1'b1, '0);

    // Abort during RUN of a length-5 launch on all channels
    cyc(1'b0, 1'b1, 1'b0, 3'b111, '0, 4'd5);
    idle(2, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b1, '0, '0, '0);
    idle(3, 1'b1, 3'b111);

    // Enable hold mid-RUN on channel 2
    cyc(1'b0, 1'b1, 1'b0, 3'b100, '0, 4'd6);
    idle(3, 1'b1, '0);
    idle(5, 1'b0, '0);
    idle(6, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b0, '0, 3'b100, '0);
    idle(2, 1'b1, '0);

    // All channels together with zero length and immediate acknowledge
    cyc(1'b0, 1'b1, 1'b0, 3'b111, 3'b111, 4'd0);
    idle(5, 1'b1, 3'b111);

    // Mid-operation reset
    cyc(1'b0, 1'b1, 1'b0, 3'b111, '0, 4'd7);
    idle(3, 1'b1, '0);
    cyc(1'b1, 1'b1, 1'b0, '0, '0, '0);
    idle(2, 1'b1, '0);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      logic r, e, a;
      logic [NCH-1:0] s, d;
      logic [DW-1:0] c;
      r = ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 59) == 0);
      e = ($urandom_range(0, 9) < 8);
      s = NCH'($urandom) & NCH'($urandom);
      d = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
      c = DW'($urandom);
      cyc(r, e, a, s, d, c);
    end

    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multidiff_fsm.md
MULTIDIFF_FSM -- requirements
Module: multidiff_fsm

Interface
REQ-001 SHALL have parameter NCH, default 3: number of independent channels.
REQ-002 SHALL have parameter DW, default 4: width of the run-length field and the run counter.
REQ-003 SHALL have parameter TMO, default 8: WAIT-state timeout in enabled cycles.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port en  in  1  global advance; when low, all state and counters hold.
REQ-007 SHALL have port abort  in  1  forces every channel to IDLE.
REQ-008 SHALL have port start  in  NCH  per-channel launch request.
REQ-009 SHALL have port done_in  in  NCH  per-channel completion acknowledge.
REQ-010 SHALL have port cfg_len  in  DW  run length, sampled at launch.
REQ-011 SHALL have port y_busy  out  NCH  channel not in IDLE.
REQ-012 SHALL have port y_req  out  NCH  channel in WAIT (requesting acknowledge).
REQ-013 SHALL have port y_fin  out  NCH  channel in FIN (one-cycle pulse).
REQ-014 SHALL have port y_sync  out  1  all channels in FIN in the same cycle.
REQ-015 SHALL have port y_err  out  NCH  sticky per-channel error flag.
REQ-016 SHALL have port state_dbg  out  3*NCH  concatenated channel state codes, channel 0 in the LSBs.

Function
REQ-017 SHALL give each channel a 3-bit state: IDLE=0, ARM=1, RUN=2, WAIT=3, FIN=4; codes 5-7 are illegal.
REQ-018 SHALL apply all transitions, counting and latching only when en=1, except abort and rst.
REQ-019 SHALL move IDLE to ARM on start[i]=1 and latch cfg_len into len_q[i], with cfg_len=0 latched as 1.
REQ-020 SHALL ignore start[i] in every state other than IDLE.
REQ-021 SHALL move ARM to RUN unconditionally and load run counter cnt[i]=len_q[i].
REQ-022 SHALL, in RUN, move to WAIT and clear the timeout counter tmo[i] when cnt[i]==1, else decrement cnt[i]; RUN therefore lasts len_q[i] enabled cycles.
REQ-023 SHALL, in WAIT, move to FIN on done_in[i]=1, else increment tmo[i].
REQ-024 SHALL, in WAIT, move to IDLE and set y_err[i] when tmo[i] reaches TMO-1 without done_in[i]; done_in[i] in that same cycle wins and goes to FIN.
REQ-025 SHALL move FIN to IDLE unconditionally.
REQ-026 SHALL, when a channel holds an illegal code, move it to IDLE on the next edge regardless of en and set y_err[i].
REQ-027 SHALL, on abort=1, put all channels in IDLE and clear cnt/tmo on the next edge with no y_fin pulse; priority is rst > abort > illegal recovery > normal transitions.
REQ-028 SHALL make y_busy, y_req, y_fin and y_sync pure decodes of the current state (Moore, zero latency), with y_sync = AND of all y_fin bits.
REQ-029 SHALL keep y_err[i] set until rst; abort does not clear it.
REQ-030 SHALL saturate cnt and tmo arithmetic at DW and clog2(TMO)+1 bits respectively, with no wrap.

Reset
REQ-031 SHALL, on rst=1 at a rising edge, set every channel to IDLE and clear len_q, cnt, tmo and y_err.
REQ-032 SHALL hold every output at 0 while reset is applied and in the cycle after it, except state_dbg, which reads all IDLE codes.
REQ-033 SHALL apply reset mid-operation identically from any state, including illegal codes.

Structure
REQ-034 SHALL place the state encodings, the illegal-code range and the default NCH/DW/TMO values in shared package multidiff_pkg.
REQ-035 SHALL implement one channel as sub-module diff_chan, instantiated NCH times by generate; y_sync is formed in the top level.

Verification
REQ-036 SHALL cover reset: rst=1 for 1 cycle from arbitrary states -> state_dbg=0, all outputs 0.
REQ-037 SHALL cover a normal run: NCH=3, ch0 start=1, cfg_len=3, en=1 -> ARM 1 cycle, RUN 3 cycles, y_req=1 until done_in[0]=1, then y_fin[0]=1 for exactly 1 cycle, then IDLE.
REQ-038 SHALL cover timeout: ch1 in WAIT, done_in=0 for 8 cycles -> IDLE, y_err[1]=1 and still 1 after a later successful run.
REQ-039 SHALL cover abort: abort=1 on RUN cycle 2 of cfg_len=5 -> all channels IDLE next cycle, y_fin stays 0.
REQ-040 SHALL cover enable hold: en=0 for 5 cycles mid-RUN -> state_dbg and cnt unchanged, and RUN completes after the remaining cycles once en=1.
REQ-041 SHALL cover sync and edge cases: all 3 channels started together with cfg_len=0 and done_in=3'b111 -> each RUN lasts 1 cycle and y_sync=1 for 1 cycle.
